// File: rtl/fetch_unit.sv
//------------------------------------------------------------------------------
// Module   : fetch_unit (with package fetch_unit_pkg)
// Purpose  : Pipelined instruction fetch. Holds the fetch PC, issues in-order
//            imem read requests (up to MAX_OUTST in flight), buffers returned
//            instructions with their PC in a fetch queue drained by decode,
//            and retargets/flushes on redirect.
// Ports    : clk, rst (async, active-high)
//            imem_req_vld/imem_req_rdy/imem_req  - read request channel
//            imem_rsp_vld/imem_rsp_rdy/imem_rsp  - read response channel
//            redirect_vld/redirect_pc            - fetch retarget
//            instr_vld/instr_rdy/instr/instr_pc  - decode channel
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package fetch_unit_pkg;
  localparam logic [1:0] MEM_READ = 2'b00;

  typedef struct packed {
    logic [1:0]  mtype;
    logic [31:0] addr;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_pkt_t;
endpackage

module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RST_PC    = 32'h0000_0000,
  parameter int unsigned     FQ_DEPTH  = 4,
  parameter int unsigned     MAX_OUTST = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_vld,
  input  logic            imem_req_rdy,
  output mem_pkt_t        imem_req,
  input  logic            imem_rsp_vld,
  output logic            imem_rsp_rdy,
  input  mem_pkt_t        imem_rsp,
  input  logic            redirect_vld,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_vld,
  input  logic            instr_rdy,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] instr_pc
);

  localparam int unsigned OPW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int unsigned OCW = $clog2(MAX_OUTST + 1);
  localparam int unsigned QPW = $clog2(FQ_DEPTH);
  localparam int unsigned QCW = $clog2(FQ_DEPTH + 1);

  logic [XLEN-1:0] r_fetch_pc;

  // In-flight PC FIFO: remembers which PC each outstanding response belongs to.
  logic [XLEN-1:0] r_of_pc [MAX_OUTST];
  logic [OPW-1:0]  r_of_wr;
  logic [OPW-1:0]  r_of_rd;
  logic [OCW-1:0]  r_outst;
  logic [OCW-1:0]  r_drop_cnt;

  // Fetch queue of {pc, instr}.
  logic [XLEN-1:0] r_fq_pc    [FQ_DEPTH];
  logic [31:0]     r_fq_instr [FQ_DEPTH];
  logic [QPW-1:0]  r_fq_wr;
  logic [QPW-1:0]  r_fq_rd;
  logic [QCW-1:0]  r_occ;

  logic            w_credit;
  logic            w_req_hs;
  logic            w_rsp_hs;
  logic            w_fq_push;
  logic            w_dec_hs;
  logic [OCW-1:0]  w_outst_nxt;
  logic            w_unused_bits;

  function automatic logic [OPW-1:0] of_inc(input logic [OPW-1:0] p);
    return (32'(p) == MAX_OUTST - 1) ? '0 : p + 1'b1;
  endfunction

  // Every in-flight request owns a queue slot, so a response always has room
  // and the response channel never needs back-pressure.
  assign w_credit     = (32'(r_occ) + 32'(r_outst)) < FQ_DEPTH;
  assign imem_req_vld = !rst && !redirect_vld && (32'(r_outst) < MAX_OUTST) && w_credit;
  assign imem_rsp_rdy = !rst;
  assign w_req_hs     = imem_req_vld && imem_req_rdy;
  // A response with nothing outstanding is a protocol violation; ignore it.
  assign w_rsp_hs     = imem_rsp_vld && imem_rsp_rdy && (r_outst != '0);
  // Responses owed to pre-redirect requests (or arriving during a redirect)
  // are discarded instead of queued.
  assign w_fq_push    = w_rsp_hs && !redirect_vld && (r_drop_cnt == '0);
  assign instr_vld    = (r_occ != '0) && !redirect_vld;
  assign w_dec_hs     = instr_vld && instr_rdy;
  assign w_outst_nxt  = r_outst + OCW'(w_req_hs) - OCW'(w_rsp_hs);

  assign instr        = r_fq_instr[r_fq_rd];
  assign instr_pc     = r_fq_pc[r_fq_rd];

  always_comb begin
    imem_req       = '0;
    imem_req.mtype = MEM_READ;
    imem_req.addr  = 32'(r_fetch_pc);
    imem_req.len   = 2'b00;
  end

  assign w_unused_bits = &{1'b0, imem_rsp.mtype, imem_rsp.addr, imem_rsp.len, redirect_pc[1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_pc <= RST_PC;
      r_of_wr    <= '0;
      r_of_rd    <= '0;
      r_outst    <= '0;
      r_drop_cnt <= '0;
      r_fq_wr    <= '0;
      r_fq_rd    <= '0;
      r_occ      <= '0;
    end else begin
      if (w_req_hs) begin
        r_of_wr    <= of_inc(r_of_wr);
        r_fetch_pc <= r_fetch_pc + XLEN'(4);
      end
      if (w_rsp_hs) begin
        r_of_rd <= of_inc(r_of_rd);
      end
      r_outst <= w_outst_nxt;
      if (redirect_vld) begin
        // No request handshakes in a redirect cycle, so this cannot collide
        // with the +4 update above.
        r_fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
        r_drop_cnt <= w_outst_nxt;
        r_fq_wr    <= '0;
        r_fq_rd    <= '0;
        r_occ      <= '0;
      end else begin
        if (w_rsp_hs && (r_drop_cnt != '0)) begin
          r_drop_cnt <= r_drop_cnt - OCW'(1);
        end
        if (w_fq_push) begin
          r_fq_wr <= r_fq_wr + QPW'(1);
        end
        if (w_dec_hs) begin
          r_fq_rd <= r_fq_rd + QPW'(1);
        end
        r_occ <= r_occ + QCW'(w_fq_push) - QCW'(w_dec_hs);
      end
    end
  end

  // Storage arrays need no reset: validity is tracked by the pointers/counts.
  always_ff @(posedge clk) begin
    if (w_req_hs) begin
      r_of_pc[r_of_wr] <= r_fetch_pc;
    end
    if (w_fq_push) begin
      r_fq_pc[r_fq_wr]    <= r_of_pc[r_of_rd];
      r_fq_instr[r_fq_wr] <= imem_rsp.data;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
//------------------------------------------------------------------------------
// Module   : tb_fetch_unit
// Purpose  : Self-checking bench for fetch_unit. A memory model answers
//            accepted requests after a random latency; a scoreboard queue
//            holds the PCs that decode must see (every request accepted since
//            the last redirect, in order) and a monitor compares decode output.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam int unsigned FQ_DEPTH  = 4;
  localparam int unsigned MAX_OUTST = 2;
  localparam logic [31:0] RST_PC    = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_vld;
  logic        imem_req_rdy = 1'b0;
  mem_pkt_t    imem_req;
  logic        imem_rsp_vld = 1'b0;
  logic        imem_rsp_rdy;
  mem_pkt_t    imem_rsp = '0;
  logic        redirect_vld = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_vld;
  logic        instr_rdy = 1'b0;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  always #5 clk = ~clk;

  fetch_unit #(
    .XLEN(32), .RST_PC(RST_PC), .FQ_DEPTH(FQ_DEPTH), .MAX_OUTST(MAX_OUTST)
  ) dut (
    .clk(clk), .rst(rst),
    .imem_req_vld(imem_req_vld), .imem_req_rdy(imem_req_rdy), .imem_req(imem_req),
    .imem_rsp_vld(imem_rsp_vld), .imem_rsp_rdy(imem_rsp_rdy), .imem_rsp(imem_rsp),
    .redirect_vld(redirect_vld), .redirect_pc(redirect_pc),
    .instr_vld(instr_vld), .instr_rdy(instr_rdy), .instr(instr), .instr_pc(instr_pc)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t       mq[$];       // accepted requests awaiting a response
  logic [31:0] exp_q[$];    // PCs decode must still deliver, in order
  logic [31:0] req_log[$];  // request addresses since last redirect/reset

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  int p_req_rdy, p_instr_rdy, p_redir, lat_min, lat_max;
  int redir_at_outst;
  bit redir_coinc, redir_force_now, redir_fired;
  logic [31:0] redir_pc_forced;

  logic [31:0] model_pc;
  logic [31:0] redir_target;
  bit          redir_pending;
  int          req_cnt, rsp_cnt, dec_cnt, first_rsp_cyc, first_vld_cyc;
  bit          prev_stall;
  mem_pkt_t    prev_req;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  task automatic enter_reset();
    rst = 1'b1;
    redirect_vld = 1'b0; redirect_pc = '0;
    imem_req_rdy = 1'b0; imem_rsp_vld = 1'b0; imem_rsp = '0; instr_rdy = 1'b0;
    mq.delete(); exp_q.delete(); req_log.delete();
    model_pc = RST_PC; redir_pending = 1'b0; prev_stall = 1'b0;
    req_cnt = 0; rsp_cnt = 0; dec_cnt = 0; first_rsp_cyc = -1; first_vld_cyc = -1;
  endtask

  task automatic leave_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Handshakes of the current cycle, sampled mid-cycle.
  task automatic observe();
    if (prev_stall && !redirect_vld) begin
      check("req_hold_vld", 64'(imem_req_vld), 64'd1);
      check("req_hold_pkt", 64'(imem_req == prev_req), 64'd1);
    end
    prev_stall = imem_req_vld && !imem_req_rdy;
    prev_req   = imem_req;
    if (redirect_vld) begin
      check("no_req_on_redirect", 64'(imem_req_vld), 64'd0);
      check("no_instr_on_redirect", 64'(instr_vld), 64'd0);
    end
    if (imem_req_vld && imem_req_rdy) begin
      check("req_addr", 64'(imem_req.addr), 64'(model_pc));
      check("req_fields", 64'({imem_req.mtype, imem_req.len, imem_req.data}),
            64'({MEM_READ, 2'b00, 32'h0}));
      exp_q.push_back(model_pc);
      req_log.push_back(imem_req.addr);
      mq.push_back('{addr: model_pc, due: cyc + int'($urandom_range(lat_max, lat_min))});
      model_pc = model_pc + 32'd4;
      req_cnt++;
    end
    if (imem_rsp_vld && imem_rsp_rdy) begin
      mq.delete(0);
      rsp_cnt++;
      if (first_rsp_cyc < 0) first_rsp_cyc = cyc;
    end
    if (instr_vld && first_vld_cyc < 0) first_vld_cyc = cyc;
    check("outst_bound", 64'(mq.size() <= MAX_OUTST), 64'd1);
    if (redirect_vld) begin
      exp_q.delete();
      req_log.delete();
      model_pc      = {redirect_pc[31:2], 2'b00};
      redir_target  = model_pc;
      redir_pending = 1'b1;
    end
  endtask

  task automatic cycle();
    bit          want;
    logic [31:0] rpc;
    @(posedge clk);
    #1;
    cyc++;
    imem_req_rdy = ($urandom_range(99) < p_req_rdy);
    instr_rdy    = ($urandom_range(99) < p_instr_rdy);
    redirect_vld = 1'b0;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rsp_vld = 1'b1;
      imem_rsp     = '{mtype: MEM_READ, addr: mq[0].addr, len: 2'b00, data: memf(mq[0].addr)};
    end else begin
      imem_rsp_vld = 1'b0;
      imem_rsp     = '0;
    end
    #1;
    want = 1'b0;
    rpc  = $urandom;
    if (redir_force_now) begin
      want = 1'b1; rpc = redir_pc_forced; redir_force_now = 1'b0; redir_fired = 1'b1;
    end else if (redir_at_outst >= 0 && mq.size() == redir_at_outst) begin
      want = 1'b1; rpc = redir_pc_forced; redir_at_outst = -1; redir_fired = 1'b1;
    end else if (redir_coinc && imem_req_vld && imem_req_rdy && imem_rsp_vld) begin
      want = 1'b1; rpc = redir_pc_forced; redir_coinc = 1'b0; redir_fired = 1'b1;
    end else if ($urandom_range(999) < p_redir) begin
      want = 1'b1;
    end
    redirect_vld = want;
    redirect_pc  = rpc;
    @(negedge clk);
    observe();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic set_knobs(input int rr, input int ir, input int pr, input int lmin, input int lmax);
    p_req_rdy = rr; p_instr_rdy = ir; p_redir = pr; lat_min = lmin; lat_max = lmax;
  endtask

  // Scoreboard monitor: decoupled from stimulus, pops on every decode handshake.
  always @(negedge clk) begin : mon
    logic [31:0] e;
    if (!rst && instr_vld && instr_rdy) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_instr: got pc %h, required none", instr_pc);
      end else begin
        e = exp_q.pop_front();
        check("instr_pc", 64'(instr_pc), 64'(e));
        check("instr_data", 64'(instr), 64'(memf(e)));
      end
      if (redir_pending) begin
        check("pc_after_redirect", 64'(instr_pc), 64'(redir_target));
        redir_pending = 1'b0;
      end
      dec_cnt++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    redir_at_outst = -1; redir_coinc = 1'b0; redir_force_now = 1'b0; redir_fired = 1'b0;
    redir_pc_forced = '0;
    set_knobs(100, 100, 0, 1, 1);

    // 1. Reset state, then streaming with zero-wait memory.
    enter_reset();
    #1;
    check("rst_req_vld", 64'(imem_req_vld), 64'd0);
    check("rst_rsp_rdy", 64'(imem_rsp_rdy), 64'd0);
    check("rst_instr_vld", 64'(instr_vld), 64'd0);
    check("rst_req_pkt", 64'(imem_req == '{mtype: MEM_READ, addr: RST_PC, len: 2'b00, data: 32'h0}), 64'd1);
    leave_reset();
    run(30);
    check("vld_latency", 64'(first_vld_cyc - first_rsp_cyc), 64'd1);
    check("stream_throughput", 64'(dec_cnt >= 27), 64'd1);

    // 2. Decode stall: credit limits issue to FQ_DEPTH requests.
    enter_reset();
    leave_reset();
    set_knobs(100, 0, 0, 1, 1);
    run(20);
    check("stall_req_cnt", 64'(req_cnt), 64'(FQ_DEPTH));
    check("stall_req_vld", 64'(imem_req_vld), 64'd0);
    set_knobs(100, 100, 0, 1, 1);
    run(20);
    if (req_log.size() > 4) check("resume_addr", 64'(req_log[4]), 64'h10);
    else check("resume_cnt", 64'(req_log.size()), 64'd5);

    // 3. Redirect with two requests in flight, memory latency 3.
    enter_reset();
    leave_reset();
    set_knobs(100, 100, 0, 3, 3);
    run(6);
    redir_fired = 1'b0; redir_pc_forced = 32'h100; redir_at_outst = 2;
    for (int i = 0; i < 20 && !redir_fired; i++) cycle();
    check("redir_outst2_fired", 64'(redir_fired), 64'd1);
    redir_at_outst = -1;
    run(20);
    if (req_log.size() > 0) check("redir_first_req", 64'(req_log[0]), 64'h100);
    else check("redir_req_cnt", 64'(req_log.size()), 64'd1);

    // 4. Misaligned redirect coincident with request and response handshakes.
    enter_reset();
    leave_reset();
    set_knobs(100, 100, 0, 1, 1);
    run(5);
    redir_fired = 1'b0; redir_pc_forced = 32'h203; redir_coinc = 1'b1;
    for (int i = 0; i < 10 && !redir_fired; i++) cycle();
    check("redir_coinc_fired", 64'(redir_fired), 64'd1);
    redir_coinc = 1'b0;
    run(10);
    if (req_log.size() > 0) check("coinc_first_req", 64'(req_log[0]), 64'h200);
    else check("coinc_req_cnt", 64'(req_log.size()), 64'd1);

    // 5. Request back-pressure, then PC wrap at the top of the address space.
    enter_reset();
    leave_reset();
    set_knobs(50, 70, 0, 1, 4);
    run(40);
    redir_pc_forced = 32'hFFFF_FFF8; redir_force_now = 1'b1;
    run(40);
    if (req_log.size() > 2) begin
      check("wrap_req0", 64'(req_log[0]), 64'hFFFF_FFF8);
      check("wrap_req1", 64'(req_log[1]), 64'hFFFF_FFFC);
      check("wrap_req2", 64'(req_log[2]), 64'h0);
    end else begin
      check("wrap_req_cnt", 64'(req_log.size() > 2), 64'd1);
    end

    // Randomised mix of latency, back-pressure, stalls and redirects.
    set_knobs(70, 60, 30, 1, 5);
    run(2000);
    set_knobs(100, 100, 0, 1, 1);
    run(20);

    // 6. Asynchronous reset mid-stream with three entries queued.
    enter_reset();
    leave_reset();
    set_knobs(100, 0, 0, 1, 1);
    for (int i = 0; i < 20 && rsp_cnt < 3; i++) cycle();
    check("pre_reset_rsp_cnt", 64'(rsp_cnt), 64'd3);
    @(posedge clk);
    #2;
    check("pre_reset_instr_vld", 64'(instr_vld), 64'd1);
    enter_reset();
    #1;
    check("async_rst_instr_vld", 64'(instr_vld), 64'd0);
    check("async_rst_req_vld", 64'(imem_req_vld), 64'd0);
    check("async_rst_rsp_rdy", 64'(imem_rsp_rdy), 64'd0);
    leave_reset();
    set_knobs(100, 100, 0, 1, 1);
    run(10);
    if (req_log.size() > 0) check("restart_addr", 64'(req_log[0]), 64'(RST_PC));
    else check("restart_req_cnt", 64'(req_log.size()), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
